draw_display_scheduler: RTL and testbench

- Sits downstream of the draw controller. Captures each drawn lottery number (1..92) on the controller's one-cycle display pulse into an on-chip result buffer.
- Once all draws have arrived, sorts the buffer ascending in place.
- Sequences the sorted results onto the two-digit seven-segment driver as a timed review, one number per dwell period.
- Owns the display path; the draw controller never drives digits directly.

---
 rtl/draw_display_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_draw_display_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_display_scheduler.sv
// Result buffer, in-place bubble sort and timed seven-segment review for the lottery draw path.
// Optional: define DRAW_DUP_CHECK_EN to reject draws that repeat a value already captured.
module draw_display_scheduler #(
    parameter int unsigned NUM_DRAWS    = 7,
    parameter int unsigned VALUE_W      = 7,
    parameter int unsigned MAX_VALUE    = 92,
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned DWELL_W      = 26
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               draw_valid,
    input  logic [VALUE_W-1:0] draw_value,
    input  logic               start_review,
    output logic [2:0]         buf_count,
    output logic               all_drawn,
    output logic               busy,
    output logic               error,
    output logic               disp_valid,
    output logic [2:0]         disp_index,
    output logic [VALUE_W-1:0] disp_value,
    output logic [3:0]         disp_tens,
    output logic [3:0]         disp_ones
);

    typedef enum logic [1:0] {COLLECT, SORT, HOLD, REVIEW} state_t;

    state_t             state, next_state;
    logic [VALUE_W-1:0] buf_mem [NUM_DRAWS];
    logic [2:0]         sort_j, sort_pass;
    logic [DWELL_W-1:0] dwell;

    logic               in_range, is_dup, accept, reject;
    logic               pair_at_end, sort_last, dwell_tc, review_last;
    logic [VALUE_W-1:0] pair_a, pair_b, pair_lo, pair_hi, sorted_head;
    logic               disp_load;
    logic [VALUE_W-1:0] disp_load_value;
    logic [2:0]         disp_load_index;

    function automatic logic [3:0] bcd_tens(input logic [VALUE_W-1:0] v);
        logic [VALUE_W-1:0] q;
        q = v / VALUE_W'(10);
        return q[3:0];
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [VALUE_W-1:0] v);
        logic [VALUE_W-1:0] r;
        r = v % VALUE_W'(10);
        return r[3:0];
    endfunction

    always_comb begin
        is_dup = 1'b0;
`ifdef DRAW_DUP_CHECK_EN
        for (int unsigned i = 0; i < NUM_DRAWS; i++) begin
            if (i < 32'(buf_count) && buf_mem[i] == draw_value)
                is_dup = 1'b1;
        end
`endif
        in_range = (draw_value != '0) && (draw_value <= VALUE_W'(MAX_VALUE));
        accept   = (state == COLLECT) && draw_valid && in_range && !is_dup;
        reject   = (state == COLLECT) && draw_valid && !(in_range && !is_dup);

        pair_a      = buf_mem[sort_j];
        pair_b      = buf_mem[sort_j + 3'd1];
        pair_lo     = (pair_a > pair_b) ? pair_b : pair_a;
        pair_hi     = (pair_a > pair_b) ? pair_a : pair_b;
        pair_at_end = (sort_j == 3'(NUM_DRAWS - 2));
        sort_last   = pair_at_end && (sort_pass == 3'(NUM_DRAWS - 2));
        // With two entries the final swap touches slot 0, so take the post-swap value
        sorted_head = (sort_j == 3'd0) ? pair_lo : buf_mem[0];

        dwell_tc    = (dwell == DWELL_W'(DWELL_CYCLES - 1));
        review_last = dwell_tc && (disp_index == 3'(NUM_DRAWS - 1));

        next_state      = state;
        disp_load       = 1'b0;
        disp_load_value = buf_mem[0];
        disp_load_index = '0;

        case (state)
            COLLECT: begin
                if (accept) begin
                    disp_load       = 1'b1;
                    disp_load_value = draw_value;
                    disp_load_index = buf_count;
                    if (buf_count == 3'(NUM_DRAWS - 1))
                        next_state = SORT;
                end
            end
            SORT: begin
                if (sort_last) begin
                    next_state      = HOLD;
                    disp_load       = 1'b1;
                    disp_load_value = sorted_head;
                end
            end
            HOLD: begin
                if (start_review) begin
                    next_state = REVIEW;
                    disp_load  = 1'b1;
                end
            end
            REVIEW: begin
                if (start_review) begin
                    disp_load = 1'b1;
                end else if (dwell_tc) begin
                    disp_load = 1'b1;
                    if (review_last) begin
                        next_state = HOLD;
                    end else begin
                        disp_load_index = disp_index + 3'd1;
                        disp_load_value = buf_mem[disp_index + 3'd1];
                    end
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= COLLECT;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_DRAWS; i++)
                buf_mem[i] <= '0;
            buf_count  <= '0;
            all_drawn  <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            disp_valid <= 1'b0;
            disp_index <= '0;
            disp_value <= '0;
            disp_tens  <= '0;
            disp_ones  <= '0;
            sort_j     <= '0;
            sort_pass  <= '0;
            dwell      <= '0;
        end else begin
            if (accept) begin
                buf_mem[buf_count] <= draw_value;
                buf_count          <= buf_count + 3'd1;
            end
            if (reject)
                error <= 1'b1;

            if (state == SORT) begin
                buf_mem[sort_j]        <= pair_lo;
                buf_mem[sort_j + 3'd1] <= pair_hi;
                if (pair_at_end) begin
                    sort_j    <= '0;
                    sort_pass <= sort_last ? 3'd0 : sort_pass + 3'd1;
                end else begin
                    sort_j <= sort_j + 3'd1;
                end
            end

            if (state == REVIEW && !start_review && !dwell_tc)
                dwell <= dwell + 1'b1;
            else
                dwell <= '0;

            if (disp_load) begin
                disp_valid <= 1'b1;
                disp_index <= disp_load_index;
                disp_value <= disp_load_value;
                disp_tens  <= bcd_tens(disp_load_value);
                disp_ones  <= bcd_ones(disp_load_value);
            end

            busy      <= (next_state == SORT) || (next_state == REVIEW);
            all_drawn <= (next_state == HOLD) || (next_state == REVIEW);
        end
    end

endmodule

// File: tb/tb_draw_display_scheduler.sv
// Directed bench for draw_display_scheduler with a short dwell period.
module tb_draw_display_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       draw_valid = 1'b0;
    logic [6:0] draw_value = '0;
    logic       start_review = 1'b0;
    logic [2:0] buf_count;
    logic       all_drawn, busy, error, disp_valid;
    logic [2:0] disp_index;
    logic [6:0] disp_value;
    logic [3:0] disp_tens, disp_ones;

    int vectors = 0;
    int miscompares = 0;
    int exp_sorted[7];
    int n;

    draw_display_scheduler #(
        .NUM_DRAWS   (7),
        .VALUE_W     (7),
        .MAX_VALUE   (92),
        .DWELL_CYCLES(4),
        .DWELL_W     (26)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .draw_valid  (draw_valid),
        .draw_value  (draw_value),
        .start_review(start_review),
        .buf_count   (buf_count),
        .all_drawn   (all_drawn),
        .busy        (busy),
        .error       (error),
        .disp_valid  (disp_valid),
        .disp_index  (disp_index),
        .disp_value  (disp_value),
        .disp_tens   (disp_tens),
        .disp_ones   (disp_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic draw(input int v);
        draw_value = 7'(v);
        draw_valid = 1'b1;
        tick();
        draw_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_review();
        start_review = 1'b1;
        tick();
        start_review = 1'b0;
    endtask

    task automatic wait_sort(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    // Expects the first REVIEW cycle to be current; walks every dwell slot then checks HOLD.
    task automatic review_check(input string tag);
        check({tag, "_busy"}, busy, 1);
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("%s_idx_%0d_%0d", tag, k, c), disp_index, k);
                check($sformatf("%s_val_%0d_%0d", tag, k, c), disp_value, exp_sorted[k]);
                if (c == 0) begin
                    check($sformatf("%s_tens_%0d", tag, k), disp_tens, exp_sorted[k] / 10);
                    check($sformatf("%s_ones_%0d", tag, k), disp_ones, exp_sorted[k] % 10);
                end
                tick();
            end
        end
        check({tag, "_hold_busy"}, busy, 0);
        check({tag, "_hold_idx"}, disp_index, 0);
        check({tag, "_hold_val"}, disp_value, exp_sorted[0]);
        check({tag, "_hold_all"}, all_drawn, 1);
    endtask

    initial begin
        int game1[7];
        int game2[7];
        game1 = '{45, 3, 92, 17, 1, 60, 8};
        game2 = '{10, 90, 33, 2, 77, 50, 41};

        #12;
        check("rst_count", buf_count, 0);
        check("rst_all", all_drawn, 0);
        check("rst_busy", busy, 0);
        check("rst_err", error, 0);
        check("rst_dvalid", disp_valid, 0);
        check("rst_idx", disp_index, 0);
        check("rst_val", disp_value, 0);
        check("rst_tens", disp_tens, 0);
        check("rst_ones", disp_ones, 0);
        reset_n = 1'b1;
        tick();

        // Illegal draws then one legal one
        draw(0);
        check("zero_err", error, 1);
        check("zero_count", buf_count, 0);
        check("zero_dvalid", disp_valid, 0);
        tick(); tick();
        draw(93);
        check("over_err", error, 1);
        check("over_count", buf_count, 0);
        tick(); tick();
        draw(5);
        check("five_count", buf_count, 1);
        check("five_err", error, 1);
        check("five_val", disp_value, 5);
        check("five_idx", disp_index, 0);
        check("five_dvalid", disp_valid, 1);
        do_reset();
        check("clr_err", error, 0);
        check("clr_count", buf_count, 0);

        // Game 1
        for (int k = 0; k < 7; k++) begin
            draw(game1[k]);
            check($sformatf("g1_count_%0d", k), buf_count, k + 1);
            check($sformatf("g1_val_%0d", k), disp_value, game1[k]);
            check($sformatf("g1_idx_%0d", k), disp_index, k);
            check($sformatf("g1_tens_%0d", k), disp_tens, game1[k] / 10);
            check($sformatf("g1_ones_%0d", k), disp_ones, game1[k] % 10);
            if (k < 6) begin
                check($sformatf("g1_busy_%0d", k), busy, 0);
                tick(); tick();
            end
        end
        check("g1_sort_busy", busy, 1);
        check("g1_sort_all", all_drawn, 0);
        wait_sort(n);
        check("g1_sort_len", n, 36);
        check("g1_all", all_drawn, 1);
        check("g1_busy_done", busy, 0);
        check("g1_head", disp_value, 1);
        check("g1_head_idx", disp_index, 0);
        check("g1_head_tens", disp_tens, 0);
        check("g1_head_ones", disp_ones, 1);

        draw(50);
        check("hold_draw_count", buf_count, 7);
        check("hold_draw_val", disp_value, 1);
        check("hold_draw_err", error, 0);

        exp_sorted = '{1, 3, 8, 17, 45, 60, 92};
        pulse_review();
        review_check("rev1");

        // Restart two cycles into index 3
        pulse_review();
        repeat (14) tick();
        check("rst_pt_idx", disp_index, 3);
        check("rst_pt_val", disp_value, 17);
        pulse_review();
        review_check("rev2");

        // Reset in the middle of SORT
        do_reset();
        for (int k = 0; k < 7; k++) begin
            draw(game2[k]);
            if (k < 6) begin
                tick(); tick();
            end
        end
        check("g2_sort_busy", busy, 1);
        repeat (10) tick();
        reset_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", buf_count, 0);
        check("mid_rst_all", all_drawn, 0);
        check("mid_rst_dvalid", disp_valid, 0);
        check("mid_rst_val", disp_value, 0);
        check("mid_rst_idx", disp_index, 0);
        check("mid_rst_tens", disp_tens, 0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 7; k++) begin
            draw(game2[k]);
            if (k < 6) begin
                tick(); tick();
            end
        end
        wait_sort(n);
        check("g3_sort_len", n, 36);
        check("g3_all", all_drawn, 1);
        check("g3_count", buf_count, 7);
        check("g3_head", disp_value, 2);
        exp_sorted = '{2, 10, 33, 41, 50, 77, 90};
        pulse_review();
        review_check("rev3");

        // Duplicate handling
        do_reset();
        draw(20);
        tick(); tick();
        draw(20);
`ifdef DRAW_DUP_CHECK_EN
        check("dup_count", buf_count, 1);
        check("dup_err", error, 1);
        check("dup_idx", disp_index, 0);
        check("dup_val", disp_value, 20);
`else
        check("dup_count", buf_count, 2);
        check("dup_err", error, 0);
        check("dup_idx", disp_index, 1);
        check("dup_val", disp_value, 20);
        tick(); tick();
        draw(30); tick(); tick();
        draw(10); tick(); tick();
        draw(70); tick(); tick();
        draw(40); tick(); tick();
        draw(60);
        wait_sort(n);
        check("dup_sort_len", n, 36);
        check("dup_head", disp_value, 10);
        exp_sorted = '{10, 20, 20, 30, 40, 60, 70};
        pulse_review();
        review_check("rev_dup");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
